// File: rtl/pdm_duty_monitor.sv
// Multi-channel PDM duty/period monitor.
// Counts PDM ones per channel over a fixed window of enabled samples, classifies
// each window's duty against a hysteresis band, and reports the distance in
// windows between consecutive rising crossings of that band.
//
// Level FSM (one per channel, stepped once per window on the duty_vld cycle)
//   state   | meaning
//   ST_INIT | no window seen since reset; first duty picks LOW or HIGH, never a crossing
//   ST_LOW  | last classified level low; duty > HYST_HI is a rising crossing
//   ST_HIGH | last classified level high; duty < HYST_LO drops back to LOW
module pdm_duty_monitor #(
  parameter int NUM_CH  = 2,
  parameter int WIN_LEN = 170,
  parameter int CNT_W   = 14,
  parameter int HYST_HI = 106,
  parameter int HYST_LO = 64,
  parameter int PER_W   = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_en,
  input  logic [NUM_CH-1:0]         i_pdm,
  output logic [NUM_CH*CNT_W-1:0]   o_duty,
  output logic                      o_duty_vld,
  output logic [NUM_CH*PER_W-1:0]   o_period,
  output logic [NUM_CH-1:0]         o_period_vld,
  output logic [NUM_CH-1:0]         o_per_ovf
);

  localparam int WCNT_W = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WIN_LEN - 1);
  localparam logic [PER_W-1:0]  PCNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  THR_HI    = CNT_W'(HYST_HI);
  localparam logic [CNT_W-1:0]  THR_LO    = CNT_W'(HYST_LO);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } lvl_t;

  logic [WCNT_W-1:0] r_wcnt;
  logic              r_duty_vld;
  logic              w_win_end;

  assign w_win_end = i_en && (r_wcnt == WCNT_LAST);

  // Shared window sample counter; frozen while i_en is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wcnt <= '0;
    end else if (i_en) begin
      r_wcnt <= w_win_end ? '0 : r_wcnt + WCNT_W'(1);
    end
  end

  // Duty-valid pulse follows the enabled cycle that closed the window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_duty_vld <= 1'b0;
    end else begin
      r_duty_vld <= w_win_end;
    end
  end

  assign o_duty_vld = r_duty_vld;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_acc;
    logic [CNT_W-1:0] r_duty;
    logic [CNT_W-1:0] w_acc_nxt;
    lvl_t             r_state;
    lvl_t             w_state_nxt;
    logic             w_rise;
    logic             r_armed;
    logic [PER_W-1:0] r_pcnt;
    logic [PER_W-1:0] r_period;
    logic             r_pvld;
    logic             r_ovf;
    logic             w_pcnt_sat;
    logic [PER_W-1:0] w_pcnt_inc;

    // The closing sample is folded in so the latched duty covers all WIN_LEN samples.
    assign w_acc_nxt = r_acc + CNT_W'(i_pdm[g]);

    // Ones accumulator and latched duty of the last completed window.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_acc  <= '0;
        r_duty <= '0;
      end else if (i_en) begin
        if (w_win_end) begin
          r_duty <= w_acc_nxt;
          r_acc  <= '0;
        end else begin
          r_acc  <= w_acc_nxt;
        end
      end
    end

    // Level FSM state register.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_state <= ST_INIT;
      end else begin
        r_state <= w_state_nxt;
      end
    end

    // Level FSM next state and rising-crossing detect, stepped only on new duty.
    always_comb begin
      w_state_nxt = r_state;
      w_rise      = 1'b0;
      if (r_duty_vld) begin
        case (r_state)
          ST_INIT: w_state_nxt = (r_duty > THR_HI) ? ST_HIGH : ST_LOW;
          ST_LOW: begin
            if (r_duty > THR_HI) begin
              w_state_nxt = ST_HIGH;
              w_rise      = 1'b1;
            end
          end
          ST_HIGH: begin
            if (r_duty < THR_LO) begin
              w_state_nxt = ST_LOW;
            end
          end
          default: w_state_nxt = ST_INIT;
        endcase
      end
    end

    assign w_pcnt_sat = (r_pcnt == PCNT_MAX);
    assign w_pcnt_inc = w_pcnt_sat ? r_pcnt : r_pcnt + PER_W'(1);

    // Window-count period measurement; the first crossing only arms it.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_armed  <= 1'b0;
        r_pcnt   <= '0;
        r_period <= '0;
        r_pvld   <= 1'b0;
        r_ovf    <= 1'b0;
      end else begin
        r_pvld <= 1'b0;
        if (r_duty_vld) begin
          if (w_rise) begin
            if (r_armed) begin
              r_period <= w_pcnt_inc;
              r_ovf    <= w_pcnt_sat;
              r_pvld   <= 1'b1;
            end
            r_armed <= 1'b1;
            r_pcnt  <= '0;
          end else begin
            r_pcnt  <= w_pcnt_inc;
          end
        end
      end
    end

    assign o_duty[g*CNT_W +: CNT_W]     = r_duty;
    assign o_period[g*PER_W +: PER_W]   = r_period;
    assign o_period_vld[g]              = r_pvld;
    assign o_per_ovf[g]                 = r_ovf;
  end

endmodule

// File: tb/tb_pdm_duty_monitor.sv
// Bench for pdm_duty_monitor: default instance plus a PER_W=4 instance sharing stimulus,
// checked every cycle against a window/crossing-index model and a few literal values.
module tb_pdm_duty_monitor;
  localparam int WIN = 170;
  localparam int HI  = 106;
  localparam int LO  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  pdm = 2'b00;

  logic [27:0] duty_a, duty_b;
  logic        dvld_a, dvld_b;
  logic [47:0] per_a;
  logic [7:0]  per_b;
  logic [1:0]  pvld_a, pvld_b, ovf_a, ovf_b;

  pdm_duty_monitor dut_a (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_pdm(pdm),
    .o_duty(duty_a), .o_duty_vld(dvld_a), .o_period(per_a),
    .o_period_vld(pvld_a), .o_per_ovf(ovf_a)
  );

  pdm_duty_monitor #(.PER_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_pdm(pdm),
    .o_duty(duty_b), .o_duty_vld(dvld_b), .o_period(per_b),
    .o_period_vld(pvld_b), .o_per_ovf(ovf_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_cnt = 0;
  int  m_ones[2] = '{0, 0};
  int  m_win = 0;
  int  m_lvl[2] = '{0, 0};     // 0 unknown, 1 low, 2 high
  int  m_last[2] = '{-1, -1};  // window index of last rising crossing
  int  e_duty[2] = '{0, 0};
  bit  e_dvld = 1'b0;
  int  e_per[2][2];
  bit  e_pvld[2][2];
  bit  e_ovf[2][2];

  function automatic int pmax(input int inst);
    return (inst == 0) ? 32'h00FF_FFFF : 15;
  endfunction

  initial begin
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++) begin
        e_per[i][c] = 0; e_pvld[i][c] = 1'b0; e_ovf[i][c] = 1'b0;
      end
  end

  always @(posedge clk) begin : model
    int gap;
    bit rise;
    if (!rst_n) begin
      m_cnt = 0; m_win = 0; e_dvld = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_ones[c] = 0; m_lvl[c] = 0; m_last[c] = -1; e_duty[c] = 0;
        for (int i = 0; i < 2; i++) begin
          e_per[i][c] = 0; e_pvld[i][c] = 1'b0; e_ovf[i][c] = 1'b0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++)
        for (int c = 0; c < 2; c++) e_pvld[i][c] = 1'b0;
      if (e_dvld) begin
        for (int c = 0; c < 2; c++) begin
          rise = 1'b0;
          if (m_lvl[c] == 0) m_lvl[c] = (e_duty[c] > HI) ? 2 : 1;
          else if (m_lvl[c] == 1 && e_duty[c] > HI) begin m_lvl[c] = 2; rise = 1'b1; end
          else if (m_lvl[c] == 2 && e_duty[c] < LO) m_lvl[c] = 1;
          if (rise) begin
            if (m_last[c] >= 0) begin
              gap = m_win - m_last[c];
              for (int i = 0; i < 2; i++) begin
                e_per[i][c]  = (gap > pmax(i)) ? pmax(i) : gap;
                e_ovf[i][c]  = (gap > pmax(i));
                e_pvld[i][c] = 1'b1;
              end
            end
            m_last[c] = m_win;
          end
        end
      end
      e_dvld = 1'b0;
      if (en) begin
        m_cnt++;
        for (int c = 0; c < 2; c++) m_ones[c] += int'(pdm[c]);
        if (m_cnt == WIN) begin
          for (int c = 0; c < 2; c++) begin e_duty[c] = m_ones[c]; m_ones[c] = 0; end
          m_cnt = 0; m_win++; e_dvld = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int q_a0[$], q_a1[$], q_b0[$], q_b1[$];

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("duty_vld_a", int'(dvld_a), int'(e_dvld));
      chk("duty_vld_b", int'(dvld_b), int'(e_dvld));
      for (int c = 0; c < 2; c++) begin
        chk("duty_a", int'(duty_a[c*14 +: 14]), e_duty[c]);
        chk("duty_b", int'(duty_b[c*14 +: 14]), e_duty[c]);
        chk("period_a", int'(per_a[c*24 +: 24]), e_per[0][c]);
        chk("period_b", int'(per_b[c*4 +: 4]), e_per[1][c]);
        chk("pvld_a", int'(pvld_a[c]), int'(e_pvld[0][c]));
        chk("pvld_b", int'(pvld_b[c]), int'(e_pvld[1][c]));
        chk("ovf_a", int'(ovf_a[c]), int'(e_ovf[0][c]));
        chk("ovf_b", int'(ovf_b[c]), int'(e_ovf[1][c]));
        if (pvld_a[c]) begin
          if (c == 0) q_a0.push_back(int'(per_a[23:0]) * 2 + int'(ovf_a[0]));
          else        q_a1.push_back(int'(per_a[47:24]) * 2 + int'(ovf_a[1]));
        end
        if (pvld_b[c]) begin
          if (c == 0) q_b0.push_back(int'(per_b[3:0]) * 2 + int'(ovf_b[0]));
          else        q_b1.push_back(int'(per_b[7:4]) * 2 + int'(ovf_b[1]));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic pbit(input int mode, input int k);
    return (mode == 2) ? logic'(k % 2) : logic'(mode);
  endfunction

  // Starts at a negedge aligned to a window start; returns at the negedge where duty_vld shows.
  task automatic run_window(input int m0, input int m1);
    en = 1'b1;
    for (int k = 0; k < WIN; k++) begin
      pdm = {pbit(m1, k), pbit(m0, k)};
      @(negedge clk);
    end
  endtask

  task automatic wait_dvld(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dvld_a && n < 1000);
  endtask

  task automatic chk_q(input string nm, input int q[$], input int e0, input int e1);
    chk({nm, "_count"}, q.size(), 2);
    if (q.size() > 0) chk({nm, "_first"}, q[0], e0);
    if (q.size() > 1) chk({nm, "_second"}, q[1], e1);
  endtask

  initial begin : timeout
    #2_000_000;
    $display("FAIL timeout no_finish_by=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    // reset state
    rst_n = 1'b0; en = 1'b0; pdm = 2'b00;
    repeat (3) @(negedge clk);
    cmp_on = 1'b1;
    chk("reset_duty", int'(duty_a), 0);
    chk("reset_period", int'(per_a), 0);
    chk("reset_flags", int'({dvld_a, pvld_a, ovf_a}), 0);

    // constant ones: first window closes 170 enabled cycles after release
    rst_n = 1'b1; en = 1'b1; pdm = 2'b11;
    wait_dvld(n);
    chk("t1_first_latency", n, 170);
    chk("t1_duty0", int'(duty_a[13:0]), 170);
    chk("t1_duty1", int'(duty_a[27:14]), 170);
    wait_dvld(n);
    chk("t1_second_latency", n, 170);

    // pause 50 cycles at wcnt=60
    repeat (60) @(negedge clk);
    en = 1'b0;
    repeat (50) @(negedge clk);
    en = 1'b1;
    wait_dvld(n);
    chk("t4_paused_latency", 60 + 50 + n, 220);
    chk("t4_duty0", int'(duty_a[13:0]), 170);

    // alternating ch0 sits inside the hysteresis band
    run_window(2, 1);
    chk("t3_duty0", int'(duty_a[13:0]), 85);
    chk("t3_duty1", int'(duty_a[27:14]), 170);
    run_window(2, 0);
    chk("t3_duty0_again", int'(duty_a[13:0]), 85);
    chk("t3_duty1_zero", int'(duty_a[27:14]), 0);

    // reset mid-window at wcnt=100
    pdm = 2'b11;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_duty_cleared", int'(duty_a), 0);
    chk("t5_flags_cleared", int'({dvld_a, pvld_a, ovf_a}), 0);
    rst_n = 1'b1;
    wait_dvld(n);
    chk("t5_latency", n, 170);

    // ch0: 5 low / 5 high windows; ch1: rises at windows 1, 21, 29
    for (int w = 0; w < 30; w++)
      run_window((w / 5) % 2, (w == 1 || w == 21 || w == 29) ? 1 : 0);
    pdm = 2'b00;
    repeat (3) @(negedge clk);
    chk_q("t2_a_ch0", q_a0, 10 * 2 + 0, 10 * 2 + 0);
    chk_q("t6_a_ch1", q_a1, 20 * 2 + 0, 8 * 2 + 0);
    chk_q("t2_b_ch0", q_b0, 10 * 2 + 0, 10 * 2 + 0);
    chk_q("t6_b_ch1", q_b1, 15 * 2 + 1, 8 * 2 + 0);

    cmp_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
